// File: rtl/fp_div_sd.sv
// Iterative IEEE-754 single/double divider, R = A / B, one quotient bit per cycle.
// Optional macro FPDIV_ROUND_EN adds a guard bit and round-to-nearest-even; default truncates.
module fp_div_sd #(
    parameter int DSTWidth = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ACT,
    input  logic [DSTWidth-1:0] DSTI,
    input  logic                SZ,
    input  logic [63:0]         A,
    input  logic [63:0]         B,
    output logic                BUSY,
    output logic                RDY,
    output logic [DSTWidth-1:0] DST,
    output logic [63:0]         R,
    output logic                SR,
    output logic                ZERO,
    output logic                SIGN,
    output logic                INF,
    output logic                NAN,
    output logic                DZ
);

`ifdef FPDIV_ROUND_EN
    localparam int QS = 26;
    localparam int QD = 55;
`else
    localparam int QS = 25;
    localparam int QD = 54;
`endif

    typedef enum logic [1:0] {IDLE, UNPACK, DIV, PACK} state_t;

    state_t state, state_nxt;

    logic [63:0]         a_r, b_r;
    logic                sz_r;
    logic [DSTWidth-1:0] dst_r;

    logic [10:0]         ea, eb, emax;
    logic [51:0]         fa, fb;
    logic [52:0]         ma_c, mb_c;
    logic signed [12:0]  e_c;
    logic                sign_c;
    logic                a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    logic [52:0]         mb_r;
    logic signed [12:0]  exp_r;
    logic [53:0]         rem;
    logic [QD-1:0]       quo;
    logic [5:0]          cnt;
    logic                rem_ge;
    logic [52:0]         rem_sub;

    logic                top;
    logic [51:0]         frac;
    logic signed [12:0]  e_n;
    logic [63:0]         res;
    logic                f_zero, f_inf, f_nan, f_dz;
`ifdef FPDIV_ROUND_EN
    logic                guard, sticky, carry;
`endif

    function automatic logic [63:0] pack_word(input logic s, input logic [10:0] e,
                                              input logic [51:0] f, input logic dbl);
        if (dbl) pack_word = {s, e, f};
        else     pack_word = {32'd0, s, e[7:0], f[22:0]};
    endfunction

`ifdef FPDIV_ROUND_EN
    // Returns {carry_out, fraction}; single results keep the carry at bit 23 of the sum.
    function automatic logic [52:0] round_rne(input logic [51:0] f, input logic g,
                                              input logic s, input logic dbl);
        logic [52:0] sum;
        logic        inc;
        inc = g & (s | f[0]);
        sum = {1'b0, f} + {52'd0, inc};
        if (dbl) round_rne = sum;
        else     round_rne = {sum[23], 29'd0, sum[22:0]};
    endfunction
`endif

    // Operand unpack from the captured words; denormals flush to zero.
    always_comb begin
        if (sz_r) begin
            ea     = a_r[62:52];
            eb     = b_r[62:52];
            fa     = a_r[51:0];
            fb     = b_r[51:0];
            emax   = 11'h7FF;
            ma_c   = {1'b1, a_r[51:0]};
            mb_c   = {1'b1, b_r[51:0]};
            e_c    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023;
            sign_c = a_r[63] ^ b_r[63];
        end else begin
            ea     = {3'b000, a_r[30:23]};
            eb     = {3'b000, b_r[30:23]};
            fa     = {29'd0, a_r[22:0]};
            fb     = {29'd0, b_r[22:0]};
            emax   = 11'h0FF;
            ma_c   = {29'd0, 1'b1, a_r[22:0]};
            mb_c   = {29'd0, 1'b1, b_r[22:0]};
            e_c    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd127;
            sign_c = a_r[31] ^ b_r[31];
        end
        a_zero = (ea == 11'd0);
        b_zero = (eb == 11'd0);
        a_inf  = (ea == emax) && (fa == 52'd0);
        b_inf  = (eb == emax) && (fb == 52'd0);
        a_nan  = (ea == emax) && (fa != 52'd0);
        b_nan  = (eb == emax) && (fb != 52'd0);
    end

    always_comb begin
        rem_ge  = (rem >= {1'b0, mb_r});
        rem_sub = rem_ge ? 53'(rem - {1'b0, mb_r}) : rem[52:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        BUSY      = (state != IDLE);
        case (state)
            IDLE:    if (ACT) state_nxt = UNPACK;
            UNPACK:  state_nxt = DIV;
            DIV:     if (cnt == 6'd0) state_nxt = PACK;
            PACK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        case (state)
            IDLE: begin
                if (ACT) begin
                    a_r   <= A;
                    b_r   <= B;
                    sz_r  <= SZ;
                    dst_r <= DSTI;
                end
            end
            UNPACK: begin
                rem   <= {1'b0, ma_c};
                mb_r  <= mb_c;
                exp_r <= e_c;
                quo   <= '0;
                cnt   <= sz_r ? 6'(QD - 1) : 6'(QS - 1);
            end
            DIV: begin
                rem <= {rem_sub, 1'b0};
                quo <= {quo[QD-2:0], rem_ge};
                cnt <= cnt - 6'd1;
            end
            default: ;
        endcase
    end

    // Normalize, round and resolve special cases from the finished quotient.
    always_comb begin
        top = sz_r ? quo[QD-1] : quo[QS-1];
        if (sz_r) frac = top ? quo[QD-2 -: 52] : quo[QD-3 -: 52];
        else      frac = {29'd0, (top ? quo[QS-2 -: 23] : quo[QS-3 -: 23])};
        e_n = top ? exp_r : exp_r - 13'sd1;
`ifdef FPDIV_ROUND_EN
        guard  = top ? quo[1] : quo[0];
        sticky = (top & quo[0]) | (rem != 54'd0);
        {carry, frac} = round_rne(frac, guard, sticky, sz_r);
        if (carry) e_n = e_n + 13'sd1;
`endif
        f_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
        f_inf  = 1'b0;
        f_zero = 1'b0;
        f_dz   = 1'b0;
        res    = '0;
        if (f_nan) begin
            res = pack_word(sign_c, 11'h7FF, {52{1'b1}}, sz_r);
        end else if (b_zero && !a_inf) begin
            f_inf = 1'b1;
            f_dz  = 1'b1;
            res   = pack_word(sign_c, 11'h7FF, 52'd0, sz_r);
        end else if (a_inf) begin
            f_inf = 1'b1;
            res   = pack_word(sign_c, 11'h7FF, 52'd0, sz_r);
        end else if (a_zero || b_inf) begin
            f_zero = 1'b1;
        end else if (e_n >= $signed({2'b00, emax})) begin
            f_inf = 1'b1;
            res   = pack_word(sign_c, 11'h7FF, 52'd0, sz_r);
        end else if (e_n <= 13'sd0) begin
            f_zero = 1'b1;
        end else begin
            res = pack_word(sign_c, e_n[10:0], frac, sz_r);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RDY  <= 1'b0;
            R    <= '0;
            DST  <= '0;
            SR   <= 1'b0;
            ZERO <= 1'b0;
            SIGN <= 1'b0;
            INF  <= 1'b0;
            NAN  <= 1'b0;
            DZ   <= 1'b0;
        end else begin
            RDY <= 1'b0;
            if (state == PACK) begin
                RDY  <= 1'b1;
                R    <= res;
                DST  <= dst_r;
                SR   <= sz_r;
                ZERO <= f_zero;
                SIGN <= sign_c;
                INF  <= f_inf;
                NAN  <= f_nan;
                DZ   <= f_dz;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_sd.sv
// Directed self-checking bench for fp_div_sd: results, flags, latency, back-pressure and abort.
module tb_fp_div_sd;

`ifdef FPDIV_ROUND_EN
    localparam int LAT_S = 28;
    localparam int LAT_D = 57;
`else
    localparam int LAT_S = 27;
    localparam int LAT_D = 56;
`endif

    logic        CLK = 1'b0;
    logic        RESET, ACT, SZ;
    logic [3:0]  DSTI, DST;
    logic [63:0] A, B, R;
    logic        BUSY, RDY, SR, ZERO, SIGN, INF, NAN, DZ;

    int checks = 0;
    int failures = 0;
    int rdy_cnt = 0;
    int lat;
    int cnt0;

    fp_div_sd #(.DSTWidth(4)) dut (
        .CLK(CLK), .RESET(RESET), .ACT(ACT), .DSTI(DSTI), .SZ(SZ), .A(A), .B(B),
        .BUSY(BUSY), .RDY(RDY), .DST(DST), .R(R), .SR(SR),
        .ZERO(ZERO), .SIGN(SIGN), .INF(INF), .NAN(NAN), .DZ(DZ)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (RDY === 1'b1) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive(input logic sz, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] t);
        SZ = sz; A = a; B = b; DSTI = t; ACT = 1'b1;
    endtask

    task automatic start(input logic sz, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] t);
        @(negedge CLK);
        drive(sz, a, b, t);
        @(negedge CLK);
        ACT = 1'b0;
    endtask

    task automatic wait_rdy(input int base, output int l);
        l = base;
        while (RDY !== 1'b1 && l < base + 200) begin
            @(negedge CLK);
            l++;
        end
    endtask

    task automatic check_res(input string tag, input logic [63:0] er, input logic [4:0] ef,
                             input logic esr, input logic [3:0] et);
        chk({tag, ".R"}, R, er);
        chk({tag, ".flags"}, 64'({ZERO, SIGN, INF, NAN, DZ}), 64'(ef));
        chk({tag, ".SR"}, 64'(SR), 64'(esr));
        chk({tag, ".DST"}, 64'(DST), 64'(et));
        chk({tag, ".BUSY"}, 64'(BUSY), 64'd0);
    endtask

    // flags order: {ZERO, SIGN, INF, NAN, DZ}
    task automatic run_op(input string tag, input logic sz, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] t,
                          input logic [63:0] er, input logic [4:0] ef);
        int l;
        start(sz, a, b, t);
        wait_rdy(0, l);
        chk({tag, ".lat"}, 64'(l), 64'(sz ? LAT_D : LAT_S));
        check_res(tag, er, ef, sz, t);
        step(1);
        chk({tag, ".pulse"}, 64'(RDY), 64'd0);
        chk({tag, ".hold"}, R, er);
    endtask

    initial begin
        RESET = 1'b1; ACT = 1'b0; SZ = 1'b0; A = '0; B = '0; DSTI = '0;
        step(3);
        chk("rst.BUSY", 64'(BUSY), 64'd0);
        chk("rst.RDY", 64'(RDY), 64'd0);
        chk("rst.R", R, 64'd0);
        chk("rst.DST", 64'(DST), 64'd0);
        chk("rst.SR", 64'(SR), 64'd0);
        chk("rst.flags", 64'({ZERO, SIGN, INF, NAN, DZ}), 64'd0);
        RESET = 1'b0;
        step(1);

        run_op("div6by2", 1'b0, 64'h0000_0000_40C0_0000, 64'h0000_0000_4000_0000, 4'd5,
               64'h0000_0000_4040_0000, 5'b00000);
        run_op("third_d", 1'b1, 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 4'd1,
               64'h3FD5_5555_5555_5555, 5'b00000);
        run_op("neghalf", 1'b0, 64'h1234_5678_BF80_0000, 64'h0000_0000_4000_0000, 4'd2,
               64'h0000_0000_BF00_0000, 5'b01000);
        run_op("onebyz", 1'b0, 64'h0000_0000_3F80_0000, 64'h0, 4'd3,
               64'h0000_0000_7F80_0000, 5'b00101);
        run_op("zbyz", 1'b0, 64'h0, 64'h0, 4'd4,
               64'h0000_0000_7FFF_FFFF, 5'b00010);
        run_op("ovf", 1'b0, 64'h0000_0000_7F00_0000, 64'h0000_0000_3E80_0000, 4'd6,
               64'h0000_0000_7F80_0000, 5'b00100);
        run_op("unf", 1'b0, 64'h0000_0000_0080_0000, 64'h0000_0000_7F00_0000, 4'd7,
               64'h0, 5'b10000);
        run_op("negz_d", 1'b1, 64'h8000_0000_0000_0000, 64'h4014_0000_0000_0000, 4'd8,
               64'h0, 5'b11000);

        // ACT while busy is dropped; ACT in the RDY cycle is accepted.
        cnt0 = rdy_cnt;
        start(1'b0, 64'h0000_0000_40C0_0000, 64'h0000_0000_4000_0000, 4'd3);
        step(9);
        drive(1'b1, 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 4'd9);
        step(1);
        ACT = 1'b0;
        wait_rdy(10, lat);
        chk("drop.lat", 64'(lat), 64'(LAT_S));
        check_res("drop", 64'h0000_0000_4040_0000, 5'b00000, 1'b0, 4'd3);
        drive(1'b0, 64'h0000_0000_BF80_0000, 64'h0000_0000_4000_0000, 4'd12);
        step(1);
        ACT = 1'b0;
        chk("b2b.BUSY", 64'(BUSY), 64'd1);
        wait_rdy(0, lat);
        chk("b2b.lat", 64'(lat), 64'(LAT_S));
        check_res("b2b", 64'h0000_0000_BF00_0000, 5'b01000, 1'b0, 4'd12);
        step(1);
        chk("b2b.count", 64'(rdy_cnt - cnt0), 64'd2);

        // Reset mid-operation aborts, then a fresh operation completes normally.
        cnt0 = rdy_cnt;
        start(1'b1, 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 4'd7);
        step(11);
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        chk("abort.BUSY", 64'(BUSY), 64'd0);
        chk("abort.RDY", 64'(RDY), 64'd0);
        chk("abort.R", R, 64'd0);
        step(1);
        drive(1'b1, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 4'hA);
        step(1);
        ACT = 1'b0;
        wait_rdy(0, lat);
        chk("restart.lat", 64'(lat), 64'(LAT_D));
        check_res("restart", 64'h4008_0000_0000_0000, 5'b00000, 1'b1, 4'hA);
        step(1);
        chk("restart.count", 64'(rdy_cnt - cnt0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_div_sd.md
Name: fp_div_sd

Overview:
- Iterative IEEE-754 single/double floating-point divider, R = A / B.
- Companion to the pipelined FP multiplier in the FPU cluster. It shares the same tag/ready result convention (ACT/DSTI in, RDY/DST out) and the same flag set, plus divide-by-zero.
- Uses a one-bit-per-cycle restoring divider. It is not pipelined: one operation in flight, with BUSY back-pressure to the issue logic.

Parameters:
- DSTWidth, 4, width of the destination tag carried from DSTI to DST.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- ACT  in  1  start request; sampled only when BUSY=0.
- DSTI  in  DSTWidth  destination tag, captured with ACT.
- SZ  in  1  operand/result size: 0 = 32-bit (A[31:0], B[31:0]), 1 = 64-bit.
- A  in  64  dividend.
- B  in  64  divisor.
- BUSY  out  1  operation in flight; ACT is ignored while high.
- RDY  out  1  one-cycle result-valid pulse.
- DST  out  DSTWidth  tag of the result.
- R  out  64  result; for 32-bit results R[63:32]=0.
- SR  out  1  size of the result (copy of captured SZ).
- ZERO, SIGN, INF, NAN, DZ  out  1 each  result flags; DZ = divide by zero.

Behaviour:
- Reset: state=IDLE; BUSY, RDY, R, DST, SR and all flags are 0. RESET mid-operation aborts the operation: no RDY, and the tag is discarded.
- States: IDLE -> UNPACK -> DIV -> PACK -> IDLE.
- IDLE: on ACT=1 at edge 0, register A, B, SZ, DSTI, set BUSY=1, go to UNPACK. ACT while BUSY=1 is dropped with no side effect.
- UNPACK (1 cycle):
  - Extract sign, exponent and fraction; the hidden 1 is prepended.
  - Exponent field 0 is treated as zero (no denormals, flush).
  - Exponent all-ones with fraction 0 is Inf; with fraction non-zero it is NaN.
  - Compute E = EA - EB + bias (127/1023) in 13-bit signed.
  - Load remainder = MA, divisor = MB, iteration counter = Q-1, where Q = 25 (single) or 54 (double).
- DIV (Q cycles), per cycle:
  - If rem >= MB then qbit=1 and rem -= MB, else qbit=0.
  - rem <<= 1; quotient shifts in qbit.
  - Counter decrements; leave DIV when the counter reaches 0.
  - The DIV sequence runs even for special-case operands, so latency is fixed.
- Normalize:
  - If quotient[Q-1]=1: fraction = quotient[Q-2:1], exponent E unchanged.
  - Otherwise: fraction = quotient[Q-3:0], exponent E-1.
  - Default rounding is truncation.
- Special-case priority, highest first:
  1. Either NaN, 0/0 or Inf/Inf -> NaN: exponent all-ones, fraction all-ones, NAN=1.
  2. Finite non-zero/0 -> Inf, INF=1, DZ=1.
  3. Inf/finite -> Inf.
  4. 0/x or finite/Inf -> zero.
  5. Normalized E >= all-ones (255/2047) -> Inf, INF=1.
  6. E <= 0 -> zero, ZERO=1.
- Zero result: R = 0 in all 64 bits. SIGN flag = signA ^ signB in all cases; for non-zero results sign bit = SIGN.
- PACK (1 cycle):
  - Register R and flags; DST = captured tag; SR = captured SZ.
  - RDY=1 for exactly one cycle; BUSY falls in the same cycle.
  - An ACT in the RDY cycle is accepted, giving back-to-back operation.
- Latency: RDY is high after edge Q+2 counting from the ACT edge: 27 cycles single, 56 double.
- Outputs R, DST, SR and flags hold their values until the next PACK or RESET.

Optional Feature:
- FPDIV_ROUND_EN, defined:
  - Q becomes 26/55 (one extra guard bit); sticky = (final remainder != 0).
  - Round to nearest even.
  - A fraction carry-out increments the exponent and may overflow to Inf.
  - Latency becomes 28/57.
- FPDIV_ROUND_EN undefined: truncation, latency 27/56.

Test Plan:
1. SZ=0, A=0x40C00000 (6.0), B=0x40000000 (2.0), DSTI=5 -> RDY 27 cycles later, R=0x0000000040400000, DST=5, all flags 0, SR=0.
2. SZ=1, A=0x3FF0000000000000, B=0x4008000000000000 (1/3) -> after 56 cycles R=0x3FD5555555555555, SR=1; SZ=0, A=0xBF800000, B=0x40000000 -> R[31:0]=0xBF000000, SIGN=1.
3. SZ=0, A=0x3F800000, B=0x00000000 -> R[31:0]=0x7F800000, INF=1, DZ=1; A=B=0 -> R[31:0]=0x7FFFFFFF, NAN=1, DZ=0.
4. SZ=0, A=0x7F000000, B=0x3E800000 -> R[31:0]=0x7F800000, INF=1; A=0x00800000, B=0x7F000000 -> R=0, ZERO=1.
5. ACT pulsed at cycles 0 and 10 with different DSTI -> exactly one RDY at cycle 27 carrying the first tag; ACT in the RDY cycle -> second RDY 27 cycles later.
6. RESET at cycle 12 of a double operation -> BUSY=0, no RDY ever appears; a new ACT at cycle 14 completes normally at cycle 14+56.
